// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes and FSM states.
// The control unit imports this package for its stall decode.
package muldiv_pkg;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO registers.
// Optional MULDIV_ABORT_EN adds an abort input that cancels an in-flight op.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
// CALC  | one multiply/divide iteration per clock, DATA_W iterations
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
`ifdef MULDIV_ABORT_EN
    input  logic              abort,
`endif
    input  logic [5:0]        functcode,
    input  logic [DATA_W-1:0] rs_content,
    input  logic [DATA_W-1:0] rt_content,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                is_div_q, is_div_d;
    logic                a_neg_q, a_neg_d;
    logic                res_neg_q, res_neg_d;
    logic                dz_q, dz_d;

    logic                abort_hit;
    logic                fn_muldiv, fn_signed, fn_div;
    logic                rs_neg, rt_neg;
    logic [DATA_W-1:0]   rs_abs, rt_abs;
    logic [DATA_W-1:0]   mul_addend;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   div_sub;
    logic [2*DATA_W-1:0] prod, prod_neg;

`ifdef MULDIV_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign fn_muldiv = (functcode == FN_MULT) || (functcode == FN_MULTU) ||
                       (functcode == FN_DIV)  || (functcode == FN_DIVU);
    assign fn_signed = (functcode == FN_MULT) || (functcode == FN_DIV);
    assign fn_div    = (functcode == FN_DIV)  || (functcode == FN_DIVU);
    assign rs_neg    = fn_signed & rs_content[DATA_W-1];
    assign rt_neg    = fn_signed & rt_content[DATA_W-1];
    assign rs_abs    = rs_neg ? -rs_content : rs_content;
    assign rt_abs    = rt_neg ? -rt_content : rt_content;

    // Multiply: {acc_hi, acc_lo} holds partial product over remaining multiplier bits.
    assign mul_addend = acc_lo_q[0] ? opa_q : '0;
    assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    // The 32-bit subtract is exact whenever div_ge holds, since the result is below the divisor.
    assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_sub   = div_shift[DATA_W-1:0] - opb_q;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_neg = -prod;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            a_neg_q   <= a_neg_d;
            res_neg_q <= res_neg_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_div_d  = is_div_q;
        a_neg_d   = a_neg_q;
        res_neg_d = res_neg_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (start && fn_muldiv) begin
                    opa_d     = rs_abs;
                    opb_d     = rt_abs;
                    acc_hi_d  = '0;
                    acc_lo_d  = fn_div ? rs_abs : rt_abs;
                    is_div_d  = fn_div;
                    a_neg_d   = rs_neg;
                    res_neg_d = rs_neg ^ rt_neg;
                    dz_d      = fn_div && (rt_content == '0);
                    cnt_d     = '0;
                    state_d   = CALC;
                end else if (start && functcode == FN_MTHI) begin
                    hi_d = rs_content;
                end else if (start && functcode == FN_MTLO) begin
                    lo_d = rs_content;
                end
            end
            CALC: begin
                if (abort_hit) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ge ? div_sub : div_shift[DATA_W-1:0];
                        acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
                    end else begin
                        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[DATA_W-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort_hit) begin
                    done_d = 1'b1;
                    if (is_div_q && dz_q) begin
                        // opa holds |rs|; re-negating recovers rs as issued.
                        hi_d = a_neg_q ? -opa_q : opa_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = a_neg_q ? -acc_hi_q : acc_hi_q;
                        lo_d = res_neg_q ? -acc_lo_q : acc_lo_q;
                    end else begin
                        {hi_d, lo_d} = res_neg_q ? prod_neg : prod;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside the ALU in the execute stage, fed by the same decoded funct and rs/rt operand contents.
- Replaces single-cycle combinational MULT/DIV with a 32-iteration shift-add multiplier and restoring divider.
- Asserts busy so the control unit can stall dependent MFHI/MFLO and further mult/div issue.

Parameters:
DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W
CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
clk  input  1  single clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  issue strobe; sampled only in IDLE
functcode  input  6  0x18 MULT, 0x19 MULTU, 0x1a DIV, 0x1b DIVU, 0x11 MTHI, 0x13 MTLO
rs_content  input  DATA_W  operand A / MTHI-MTLO source
rt_content  input  DATA_W  operand B
busy  output  1  operation in flight
done  output  1  one-cycle pulse, HI/LO just updated by mult/div
HI  output  DATA_W  architectural HI register
LO  output  DATA_W  architectural LO register

Behaviour:
- Reset (reset_n low at an edge): state IDLE, HI=0, LO=0, busy=0, done=0, counter=0. Overrides any in-flight op (reset mid-op discards it, no done).
- States: IDLE, CALC, FIX.
- IDLE + start + mult/div funct at edge E0: latch |rs|, |rt| (abs only for signed ops), result-sign flags, div-by-zero flag; counter=0; busy=1; go to CALC.
- CALC: one iteration per edge. Multiply: 64-bit shift-add. Divide: restoring, 1 quotient bit per edge. After edge E32 (counter reaches DATA_W-1), go to FIX.
- FIX, edge E33: apply sign correction, write HI/LO, busy=0, done=1 for exactly one cycle, go to IDLE. Total latency 33 edges from accepted start to HI/LO valid.
- Signed mult: 64-bit product negated if operand signs differ.
- Signed div: quotient (LO) negated if signs differ; remainder (HI) takes the sign of the dividend.
- Divide by zero (rt=0, DIV or DIVU): HI=rs_content as issued, LO=all ones. Full latency still taken.
- Overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO + start in IDLE: HI (resp. LO) = rs_content at E0. busy stays 0, no done.
- start while busy: ignored, no effect on the in-flight op; the control unit must stall.
- start with any other funct: ignored.
- HI/LO hold their value at all times except the FIX write, MTHI/MTLO, and reset.

Optional Feature:
MULDIV_ABORT_EN
- Defined: adds input abort (1 bit). abort high at an edge while busy returns to IDLE: busy=0, no done, HI/LO unchanged. abort has priority over FIX completion. abort is ignored in IDLE. reset_n still overrides it.
- Undefined: no abort port; every accepted op runs to completion.

Decomposition:
- muldiv_pkg: funct localparams (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO) and the state enum typedef (IDLE/CALC/FIX). Shared with the control unit for stall decode.
- No sub-module. The iteration datapath stays inline in muldiv_unit.

Test Plan:
1. MULT rs=0xFFFFFFFD (-3), rt=7: busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done high exactly 1 cycle.
2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
3. DIV rs=0xFFFFFFF9 (-7), rt=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2: LO=3, HI=1.
4. DIVU rs=5, rt=0: HI=5, LO=0xFFFFFFFF after 33 cycles. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
5. MTHI rs=0x1234 in IDLE: HI=0x1234 next cycle, busy=0, no done. Then issue MULT 2*3 and pulse start with DIVU at cycle 5: DIVU ignored, final LO=6, HI=0.
6. reset_n low at cycle 10 of a MULT: HI=0, LO=0, busy=0, no done. With MULDIV_ABORT_EN, abort at cycle 10: prior HI/LO retained, busy=0 next cycle.
